// File: rtl/alarm_ctrl.sv
// ---------------------------------------------------------------------------
// alarm_ctrl
//   Failed-entry supervisor for the 4-bit safe box. Counts consecutive wrong
//   code submissions coming from the password comparator. When the count
//   reaches MAX_FAILS it raises `alarm` for ALARM_TICKS time ticks. A silent
//   lockout of LOCK_TICKS ticks follows, and then it re-arms. `admin_clear`
//   aborts the alarm or lockout at once and clears the failure count.
//
// Parameters
//   MAX_FAILS    consecutive failures that trigger the alarm (1..7)
//   TICK_DIV     clk cycles per time tick (>=2)
//   ALARM_TICKS  ticks `alarm` stays high (>=1)
//   LOCK_TICKS   ticks of silent lockout after the alarm (>=1)
//
// Ports
//   clk          in   system clock
//   rst_n        in   asynchronous, active-low reset
//   check_valid  in   1-cycle strobe: a code was submitted
//   check_ok     in   comparator result, qualified by check_valid
//   admin_clear  in   1-cycle strobe: abort alarm/lockout, clear failures
//   alarm        out  high only while in ALARM
//   locked       out  high in ALARM and LOCKOUT
//   unlock       out  1-cycle pulse: correct code accepted
//   reject       out  1-cycle pulse: submission ignored while locked
//   fail_cnt     out  consecutive failures so far (saturates at MAX_FAILS-1)
//
// All outputs are registered, so a response appears one cycle after the
// edge that samples the inputs.
// ---------------------------------------------------------------------------
module alarm_ctrl #(
  parameter int MAX_FAILS   = 3,
  parameter int TICK_DIV    = 800000,
  parameter int ALARM_TICKS = 5,
  parameter int LOCK_TICKS  = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       check_valid,
  input  logic       check_ok,
  input  logic       admin_clear,
  output logic       alarm,
  output logic       locked,
  output logic       unlock,
  output logic       reject,
  output logic [2:0] fail_cnt
);

  // Prescaler counts 0..TICK_DIV-1. The tick counter counts 0..N-1 within
  // the current timed state. Both are cleared at their terminal count, so
  // neither of them can wrap.
  localparam int PW       = $clog2(TICK_DIV);
  localparam int TICK_MAX = (ALARM_TICKS > LOCK_TICKS) ? ALARM_TICKS : LOCK_TICKS;
  localparam int TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0] ALARM_LAST = TW'(ALARM_TICKS - 1);
  localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_TICKS - 1);
  localparam logic [2:0]    FAIL_LAST  = 3'(MAX_FAILS - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ALARM   = 2'd1;
  localparam logic [1:0] ST_LOCKOUT = 2'd2;

  logic [1:0]    state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [2:0]    fail_cnt_reg, fail_cnt_next;
  logic          alarm_reg, alarm_next;
  logic          locked_reg, locked_next;
  logic          unlock_reg, unlock_next;
  logic          reject_reg, reject_next;

  logic tick;
  logic phase_last;

  assign tick       = (presc_reg == PRESC_LAST);
  // This is the last tick of the timed state we are in. It is only
  // meaningful in ALARM or LOCKOUT.
  assign phase_last = (state_reg == ST_ALARM) ? (tick_cnt_reg == ALARM_LAST)
                                              : (tick_cnt_reg == LOCK_LAST);

  always_comb begin
    state_next    = state_reg;
    presc_next    = presc_reg;
    tick_cnt_next = tick_cnt_reg;
    fail_cnt_next = fail_cnt_reg;
    unlock_next   = 1'b0;
    reject_next   = 1'b0;

    if (admin_clear) begin
      // admin_clear outranks any submission in the same cycle. Because
      // unlock_next and reject_next stay at their defaults, neither pulse
      // is produced.
      state_next    = ST_IDLE;
      presc_next    = '0;
      tick_cnt_next = '0;
      fail_cnt_next = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          presc_next    = '0;
          tick_cnt_next = '0;
          if (check_valid) begin
            if (check_ok) begin
              unlock_next   = 1'b1;
              fail_cnt_next = '0;
            end else if (fail_cnt_reg >= FAIL_LAST) begin
              // This failure reaches MAX_FAILS. The count restarts from 0
              // for the next round once the alarm/lockout cycle is over.
              state_next    = ST_ALARM;
              fail_cnt_next = '0;
            end else begin
              fail_cnt_next = fail_cnt_reg + 3'd1;
            end
          end
        end

        ST_ALARM, ST_LOCKOUT: begin
          // A submission made while locked is only acknowledged. It does not
          // touch fail_cnt or the timers.
          reject_next = check_valid;
          if (tick) begin
            presc_next = '0;
            if (phase_last) begin
              state_next    = (state_reg == ST_ALARM) ? ST_LOCKOUT : ST_IDLE;
              tick_cnt_next = '0;
            end else begin
              tick_cnt_next = tick_cnt_reg + TW'(1);
            end
          end else begin
            presc_next = presc_reg + PW'(1);
          end
        end

        default: begin
          state_next    = ST_IDLE;
          presc_next    = '0;
          tick_cnt_next = '0;
          fail_cnt_next = '0;
        end
      endcase
    end
  end

  // The level outputs are decoded from the next state. They are therefore
  // registered alongside state_reg and never glitch.
  always_comb begin
    alarm_next  = (state_next == ST_ALARM);
    locked_next = (state_next == ST_ALARM) || (state_next == ST_LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      presc_reg    <= '0;
      tick_cnt_reg <= '0;
      fail_cnt_reg <= '0;
      alarm_reg    <= 1'b0;
      locked_reg   <= 1'b0;
      unlock_reg   <= 1'b0;
      reject_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      presc_reg    <= presc_next;
      tick_cnt_reg <= tick_cnt_next;
      fail_cnt_reg <= fail_cnt_next;
      alarm_reg    <= alarm_next;
      locked_reg   <= locked_next;
      unlock_reg   <= unlock_next;
      reject_reg   <= reject_next;
    end
  end

  assign alarm    = alarm_reg;
  assign locked   = locked_reg;
  assign unlock   = unlock_reg;
  assign reject   = reject_reg;
  assign fail_cnt = fail_cnt_reg;

endmodule

// File: tb/tb_alarm_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alarm_ctrl
//   Scoreboard bench for alarm_ctrl with TICK_DIV=4, ALARM_TICKS=3,
//   LOCK_TICKS=2 and MAX_FAILS=3.
//
//   The stimulus drives inputs 1 time unit after a rising edge. When it
//   issues stimulus, it queues the output events it expects, each stamped
//   with the cycle number. An event is any pulse on unlock or reject, or any
//   change of alarm, locked or fail_cnt.
//
//   The monitor samples at every falling edge. Each time it detects an event
//   it pops the earliest expectation and compares cycle number and outputs.
//   Any expectation still left in the queue at the end counts as a missed
//   event.
// ---------------------------------------------------------------------------
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       check_valid;
  logic       check_ok;
  logic       admin_clear;
  logic       alarm;
  logic       locked;
  logic       unlock;
  logic       reject;
  logic [2:0] fail_cnt;

  alarm_ctrl #(
    .MAX_FAILS  (3),
    .TICK_DIV   (4),
    .ALARM_TICKS(3),
    .LOCK_TICKS (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .check_valid(check_valid),
    .check_ok   (check_ok),
    .admin_clear(admin_clear),
    .alarm      (alarm),
    .locked     (locked),
    .unlock     (unlock),
    .reject     (reject),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic       a;
    logic       l;
    logic       u;
    logic       r;
    logic [2:0] f;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  bit  mon_en   = 1'b0;

  // Insert an expectation so that the queue stays ordered by cycle.
  task automatic expect_ev(input int at, input logic a, input logic l,
                           input logic u, input logic r, input logic [2:0] f);
    ev_t e;
    int  i;
    e.at = at; e.a = a; e.l = l; e.u = u; e.r = r; e.f = f;
    i = 0;
    while (i < exp_q.size() && exp_q[i].at <= at) i++;
    exp_q.insert(i, e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic strobe(input logic ok);
    check_valid = 1'b1;
    check_ok    = ok;
    tick();
    check_valid = 1'b0;
    check_ok    = 1'b0;
  endtask

  task automatic admin_pulse();
    admin_clear = 1'b1;
    tick();
    admin_clear = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
      $display("check %s: %0d", name, got);
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: detect output events and compare them against the scoreboard.
  initial begin
    logic       p_a = 1'b0;
    logic       p_l = 1'b0;
    logic [2:0] p_f = 3'd0;
    ev_t        e;
    forever begin
      @(negedge clk);
      if (mon_en && (unlock || reject || alarm !== p_a || locked !== p_l || fail_cnt !== p_f)) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL event: unexpected at cyc %0d a=%b l=%b u=%b r=%b f=%0d, expected none",
                   cyc, alarm, locked, unlock, reject, fail_cnt);
        end else begin
          e = exp_q.pop_front();
          if (e.at == cyc && alarm === e.a && locked === e.l && unlock === e.u &&
              reject === e.r && fail_cnt === e.f) begin
            n_pass++;
            $display("event cyc %0d a=%b l=%b u=%b r=%b f=%0d ok",
                     cyc, alarm, locked, unlock, reject, fail_cnt);
          end else begin
            $display("FAIL event: got cyc %0d a=%b l=%b u=%b r=%b f=%0d, expected cyc %0d a=%b l=%b u=%b r=%b f=%0d",
                     cyc, alarm, locked, unlock, reject, fail_cnt,
                     e.at, e.a, e.l, e.u, e.r, e.f);
          end
        end
      end
      p_a = alarm;
      p_l = locked;
      p_f = fail_cnt;
    end
  end

  initial begin
    int c;
    rst_n       = 1'b0;
    check_valid = 1'b0;
    check_ok    = 1'b0;
    admin_clear = 1'b0;
    idle(3);
    chk("reset_alarm",    {7'd0, alarm},  8'd0);
    chk("reset_locked",   {7'd0, locked}, 8'd0);
    chk("reset_fail_cnt", {5'd0, fail_cnt}, 8'd0);
    rst_n = 1'b1;
    idle(2);
    mon_en = 1'b1;

    // Two wrong codes, then the right one.
    c = cyc;
    expect_ev(c + 1, 0, 0, 0, 0, 3'd1);
    expect_ev(c + 2, 0, 0, 0, 0, 3'd2);
    expect_ev(c + 3, 0, 0, 1, 0, 3'd0);
    strobe(0); strobe(0); strobe(1);
    idle(4);

    // Three wrong codes: alarm for 12 cycles, then locked for 8 more.
    c = cyc;
    expect_ev(c + 1,  0, 0, 0, 0, 3'd1);
    expect_ev(c + 2,  0, 0, 0, 0, 3'd2);
    expect_ev(c + 3,  1, 1, 0, 0, 3'd0);
    expect_ev(c + 15, 0, 1, 0, 0, 3'd0);
    expect_ev(c + 23, 0, 0, 0, 0, 3'd0);
    strobe(0); strobe(0); strobe(0);
    wait_until(c + 27);

    // Submissions during ALARM and LOCKOUT are rejected; timing unchanged.
    c = cyc;
    expect_ev(c + 1,  0, 0, 0, 0, 3'd1);
    expect_ev(c + 2,  0, 0, 0, 0, 3'd2);
    expect_ev(c + 3,  1, 1, 0, 0, 3'd0);
    expect_ev(c + 7,  1, 1, 0, 1, 3'd0);
    expect_ev(c + 15, 0, 1, 0, 0, 3'd0);
    expect_ev(c + 19, 0, 1, 0, 1, 3'd0);
    expect_ev(c + 23, 0, 0, 0, 0, 3'd0);
    strobe(0); strobe(0); strobe(0);
    wait_until(c + 6);
    strobe(1);
    wait_until(c + 18);
    strobe(1);
    wait_until(c + 27);

    // admin_clear together with check_valid in cycle 5 of ALARM.
    c = cyc;
    expect_ev(c + 1, 0, 0, 0, 0, 3'd1);
    expect_ev(c + 2, 0, 0, 0, 0, 3'd2);
    expect_ev(c + 3, 1, 1, 0, 0, 3'd0);
    expect_ev(c + 8, 0, 0, 0, 0, 3'd0);
    strobe(0); strobe(0); strobe(0);
    wait_until(c + 7);
    check_valid = 1'b1;
    check_ok    = 1'b1;
    admin_clear = 1'b1;
    tick();
    check_valid = 1'b0;
    check_ok    = 1'b0;
    admin_clear = 1'b0;
    wait_until(c + 30);

    // Wrong, wrong, admin_clear, wrong: the count restarts.
    c = cyc;
    expect_ev(c + 1, 0, 0, 0, 0, 3'd1);
    expect_ev(c + 2, 0, 0, 0, 0, 3'd2);
    expect_ev(c + 3, 0, 0, 0, 0, 3'd0);
    expect_ev(c + 4, 0, 0, 0, 0, 3'd1);
    strobe(0); strobe(0); admin_pulse(); strobe(0);
    idle(4);

    // Clear the count, then check that asynchronous reset mid-ALARM drops
    // the outputs without a clock edge.
    c = cyc;
    expect_ev(c + 1, 0, 0, 0, 0, 3'd0);
    admin_pulse();
    idle(2);
    c = cyc;
    expect_ev(c + 1, 0, 0, 0, 0, 3'd1);
    expect_ev(c + 2, 0, 0, 0, 0, 3'd2);
    expect_ev(c + 3, 1, 1, 0, 0, 3'd0);
    strobe(0); strobe(0); strobe(0);
    wait_until(c + 6);
    #2;
    mon_en = 1'b0;
    chk("alarm_before_reset", {7'd0, alarm}, 8'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_alarm",    {7'd0, alarm},  8'd0);
    chk("async_reset_locked",   {7'd0, locked}, 8'd0);
    chk("async_reset_fail_cnt", {5'd0, fail_cnt}, 8'd0);
    chk("async_reset_unlock",   {7'd0, unlock}, 8'd0);
    chk("async_reset_reject",   {7'd0, reject}, 8'd0);
    idle(2);
    rst_n = 1'b1;
    tick();
    mon_en = 1'b1;
    c = cyc;
    expect_ev(c + 1, 0, 0, 0, 0, 3'd1);
    strobe(0);
    idle(20);

    while (exp_q.size() > 0) begin
      ev_t e;
      e = exp_q.pop_front();
      n_checks++;
      $display("FAIL missing_event: got nothing, expected cyc %0d a=%b l=%b u=%b r=%b f=%0d",
               e.at, e.a, e.l, e.u, e.r, e.f);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
